conv_window_gen: RTL and testbench

- Upstream feeder for the conv/FC classifier top.
- Accepts a raster pixel stream of one IMG_H x IMG_W 8-bit image through a valid/ready handshake and buffers K rows in line buffers.
- For each output row, presents all OUT_COLS sliding KxK windows in parallel, in the [cols][taps] layout the conv array consumes as its kernel-matrix operand.
- Emits one bundle per output row: OUT_ROWS bundles per frame.

---
 rtl/conv_window_gen_if.sv | 29 ++
 rtl/conv_window_gen.sv | 185 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-bundle-out handshake bundle for conv_window_gen.
// slave: the window generator's view; master: the pixel source / window consumer side.
interface conv_window_gen_if #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned K     = 3,
   parameter int unsigned PIX_W = 8
);
   localparam int unsigned OUT_COLS = IMG_W - K + 1;
   localparam int unsigned ROW_W    = 5;

   logic                                  i_pre_valid;
   logic                                  o_pre_ready;
   logic [PIX_W-1:0]                      i_pix;
   logic                                  o_post_valid;
   logic                                  i_post_ready;
   logic [OUT_COLS-1:0][K*K-1:0][PIX_W-1:0] o_window;
   logic [ROW_W-1:0]                      o_row;
   logic                                  o_frame_last;

   modport slave (
      input  i_pre_valid, i_pix, i_post_ready,
      output o_pre_ready, o_post_valid, o_window, o_row, o_frame_last
   );

   modport master (
      output i_pre_valid, i_pix, i_post_ready,
      input  o_pre_ready, o_post_valid, o_window, o_row, o_frame_last
   );
endinterface

// File: rtl/conv_window_gen.sv
// Buffers K raster rows and presents all sliding KxK windows of one output row per bundle.
// Optional CONV_WINDOW_OVERLAP_EN: a spare line buffer keeps loading pixels while a bundle is held.
module conv_window_gen #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned K     = 3,
   parameter int unsigned PIX_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   conv_window_gen_if.slave bus
);
   localparam int unsigned OUT_COLS = IMG_W - K + 1;
   localparam int unsigned OUT_ROWS = IMG_H - K + 1;
   localparam int unsigned TAPS     = K * K;
`ifdef CONV_WINDOW_OVERLAP_EN
   localparam int unsigned NB       = K + 1;
`else
   localparam int unsigned NB       = K;
`endif
   localparam int unsigned COL_W    = $clog2(IMG_W);
   localparam int unsigned RIN_W    = $clog2(IMG_H);
   localparam int unsigned PTR_W    = $clog2(NB);
   localparam int unsigned OC_W     = $clog2(OUT_COLS);
   localparam int unsigned TAP_W    = $clog2(TAPS);
   localparam int unsigned ROW_W    = 5;

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [RIN_W-1:0] rin_q, rin_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] old_q, old_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             spare_q, spare_d;
   logic             pre_ready_q, pre_ready_d;
   logic             post_valid_q, post_valid_d;
   logic             frame_last_q, frame_last_d;
   logic             accept, row_done, fire;

   logic [PIX_W-1:0] lb_q [NB][IMG_W];
   logic [OUT_COLS-1:0][TAPS-1:0][PIX_W-1:0] win_c;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      return PTR_W'(s % NB);
   endfunction

   assign accept   = bus.i_pre_valid & pre_ready_q;
   assign row_done = accept & (col_q == COL_W'(IMG_W - 1));
   assign fire     = (state_q == S_EMIT) & bus.i_post_ready;

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      rin_d        = rin_q;
      wr_d         = wr_q;
      old_d        = old_q;
      row_d        = row_q;
      spare_d      = spare_q;
      pre_ready_d  = 1'b1;
      post_valid_d = 1'b0;
      frame_last_d = 1'b0;

      if (accept) begin
         col_d = row_done ? '0 : col_q + COL_W'(1);
      end
      if (row_done) begin
         rin_d = (rin_q == RIN_W'(IMG_H - 1)) ? '0 : rin_q + RIN_W'(1);
         wr_d  = ptr_add(wr_q, 1);
      end

      case (state_q)
         S_FILL: begin
            if (row_done && (rin_q >= RIN_W'(K - 1))) begin
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
`ifdef CONV_WINDOW_OVERLAP_EN
            if (row_done) begin
               spare_d = 1'b1;
            end
`endif
            if (fire) begin
               spare_d = 1'b0;
               if (row_q == ROW_W'(OUT_ROWS - 1)) begin
                  row_d   = '0;
                  state_d = S_FILL;
`ifdef CONV_WINDOW_OVERLAP_EN
                  // New frame's row 0 lives in the buffer that was the spare
                  old_d   = ptr_add(old_q, K);
`else
                  col_d   = '0;
                  rin_d   = '0;
                  wr_d    = '0;
                  old_d   = '0;
`endif
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  old_d   = ptr_add(old_q, 1);
`ifdef CONV_WINDOW_OVERLAP_EN
                  state_d = (spare_q | row_done) ? S_EMIT : S_FILL;
`else
                  state_d = S_FILL;
`endif
               end
            end
         end
         default: state_d = S_FILL;
      endcase

      if (state_d == S_EMIT) begin
         post_valid_d = 1'b1;
         frame_last_d = (row_d == ROW_W'(OUT_ROWS - 1));
`ifdef CONV_WINDOW_OVERLAP_EN
         pre_ready_d  = ~spare_d;
`else
         pre_ready_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_FILL;
         col_q        <= '0;
         rin_q        <= '0;
         wr_q         <= '0;
         old_q        <= '0;
         row_q        <= '0;
         spare_q      <= 1'b0;
         pre_ready_q  <= 1'b1;
         post_valid_q <= 1'b0;
         frame_last_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         rin_q        <= rin_d;
         wr_q         <= wr_d;
         old_q        <= old_d;
         row_q        <= row_d;
         spare_q      <= spare_d;
         pre_ready_q  <= pre_ready_d;
         post_valid_q <= post_valid_d;
         frame_last_q <= frame_last_d;
      end
   end

   // Line buffers, written at the current column of the write-pointer row
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned b = 0; b < NB; b++) begin
            for (int unsigned x = 0; x < IMG_W; x++) begin
               lb_q[PTR_W'(b)][COL_W'(x)] <= '0;
            end
         end
      end else if (accept) begin
         lb_q[wr_q][col_q] <= bus.i_pix;
      end
   end

   // Window view: oldest buffered row maps to ky = 0
   always_comb begin
      win_c = '0;
      for (int unsigned c = 0; c < OUT_COLS; c++) begin
         for (int unsigned ky = 0; ky < K; ky++) begin
            for (int unsigned kx = 0; kx < K; kx++) begin
               win_c[OC_W'(c)][TAP_W'(ky * K + kx)] = lb_q[ptr_add(old_q, ky)][COL_W'(c + kx)];
            end
         end
      end
   end

   assign bus.o_pre_ready  = pre_ready_q;
   assign bus.o_post_valid = post_valid_q;
   assign bus.o_row        = row_q;
   assign bus.o_frame_last = frame_last_q;
   assign bus.o_window     = win_c;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: full frames, backpressure hold, random gaps, mid-frame reset.
module tb_conv_window_gen;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int K     = 3;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NBUN  = IMG_H - K + 1;
   localparam int NCOL  = IMG_W - K + 1;
`ifdef CONV_WINDOW_OVERLAP_EN
   localparam int EXP_CYC = NPIX + 1;
`else
   localparam int EXP_CYC = NPIX + NBUN;
`endif

   logic clk;
   logic rst;
   conv_window_gen_if #(.IMG_W(IMG_W), .K(K), .PIX_W(8)) bus ();

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_cnt, bun_idx, first_acc_cyc, last_acc_cyc, last_fire_cyc;
   logic prev_valid, prev_fire;
   logic [4:0] prev_row;
   logic [NCOL-1:0][K*K-1:0][7:0] prev_win;
   int first_exp [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
   int last_exp  [9] = '{213, 214, 215, 241, 242, 243, 13, 14, 15};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pv(input int y, input int x);
      return 8'((y * IMG_W + x) % 256);
   endfunction

   function automatic logic [71:0] exp_col(input int r, input int c);
      logic [71:0] e;
      e = '0;
      for (int ky = 0; ky < K; ky++)
         for (int kx = 0; kx < K; kx++)
            e[(ky * K + kx) * 8 +: 8] = pv(r + ky, c + kx);
      return e;
   endfunction

   task automatic clear_mon();
      acc_cnt = 0; bun_idx = 0; first_acc_cyc = 0; last_acc_cyc = 0; last_fire_cyc = 0;
      prev_valid = 1'b0; prev_fire = 1'b0; prev_row = '0; prev_win = '0;
   endtask

   // Monitor: latency, hold stability and window contents at each fire
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_pre_valid && bus.o_pre_ready) begin
            acc_cnt++;
            if (acc_cnt == 1) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         if (bus.o_post_valid) begin
            if (prev_valid && !prev_fire) begin
               check("hold_win", 128'(bus.o_window == prev_win), 128'(1));
               check("hold_row", 128'(bus.o_row), 128'(prev_row));
`ifndef CONV_WINDOW_OVERLAP_EN
            end else begin
               check($sformatf("lat_acc_b%0d", bun_idx), 128'(acc_cnt), 128'(K * IMG_W + IMG_W * bun_idx));
               check($sformatf("lat_cyc_b%0d", bun_idx), 128'(last_acc_cyc), 128'(cyc - 1));
`endif
            end
`ifndef CONV_WINDOW_OVERLAP_EN
            check("emit_pre_ready", 128'(bus.o_pre_ready), 128'(0));
`endif
            if (bus.i_post_ready) begin
               check($sformatf("row_b%0d", bun_idx), 128'(bus.o_row), 128'(bun_idx));
               check($sformatf("last_b%0d", bun_idx), 128'(bus.o_frame_last), 128'(bun_idx == NBUN - 1));
               for (int c = 0; c < NCOL; c++)
                  check($sformatf("win_r%0d_c%0d", bun_idx, c), 128'(bus.o_window[c]), 128'(exp_col(bun_idx, c)));
               for (int t = 0; t < K * K; t++) begin
                  if (bun_idx == 0)
                     check($sformatf("b0_c0_tap%0d", t), 128'(bus.o_window[0][t]), 128'(first_exp[t]));
                  if (bun_idx == NBUN - 1)
                     check($sformatf("b25_c25_tap%0d", t), 128'(bus.o_window[NCOL-1][t]), 128'(last_exp[t]));
               end
               bun_idx++;
               last_fire_cyc = cyc;
            end
         end
         prev_valid = bus.o_post_valid;
         prev_fire  = bus.o_post_valid & bus.i_post_ready;
         prev_row   = bus.o_row;
         prev_win   = bus.o_window;
      end
   end

   // Called at posedge+1; presents pixels (with optional random gaps) until npix are accepted
   task automatic send_frame(input int npix, input int gap_pct);
      int n = 0;
      int g = 0;
      logic acc;
      while (n < npix && g < 20000) begin
         bus.i_pre_valid = (32'($urandom_range(99)) >= 32'(gap_pct));
         bus.i_pix = 8'(n % 256);
         @(negedge clk);
         acc = bus.i_pre_valid && bus.o_pre_ready;
         @(posedge clk); #1;
         if (acc) n++;
         g++;
      end
      bus.i_pre_valid = 1'b0;
      if (n < npix) check("send_timeout", 128'(n), 128'(npix));
   endtask

   task automatic wait_bundles(input int nb);
      int g = 0;
      while (bun_idx < nb && g < 4000) begin
         @(posedge clk); #1;
         g++;
      end
      check("bundle_count", 128'(bun_idx), 128'(nb));
   endtask

   task automatic hold_at_row(input int r, input int cycles);
      int g = 0;
      while (!(bus.o_post_valid && bus.o_row == 5'(r)) && g < 4000) begin
         @(posedge clk); #1;
         g++;
      end
      check("hold_reached", 128'(bus.o_post_valid && bus.o_row == 5'(r)), 128'(1));
      bus.i_post_ready = 1'b0;
      repeat (cycles) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit rnd_done;
      rst = 1'b1;
      bus.i_pre_valid  = 1'b0;
      bus.i_pix        = '0;
      bus.i_post_ready = 1'b0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 128'(bus.o_post_valid), 128'(0));
      check("rst_ready", 128'(bus.o_pre_ready), 128'(1));
      check("rst_row", 128'(bus.o_row), 128'(0));
      check("rst_last", 128'(bus.o_frame_last), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Frame 1: continuous stream, downstream always ready
      clear_mon();
      bus.i_post_ready = 1'b1;
      send_frame(NPIX, 0);
      wait_bundles(NBUN);
      check("acc_count", 128'(acc_cnt), 128'(NPIX));
      check("frame_cycles", 128'(last_fire_cyc - first_acc_cyc + 1), 128'(EXP_CYC));
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("no_extra_bundle", 128'(bun_idx), 128'(NBUN));
      check("idle_valid", 128'(bus.o_post_valid), 128'(0));

      // Frame 2: hold bundle 3 for 20 cycles
      clear_mon();
      bus.i_post_ready = 1'b1;
      fork
         send_frame(NPIX, 0);
         begin
            hold_at_row(3, 20);
            check("held_valid", 128'(bus.o_post_valid), 128'(1));
            check("held_row", 128'(bus.o_row), 128'(3));
`ifndef CONV_WINDOW_OVERLAP_EN
            check("held_pre_ready", 128'(bus.o_pre_ready), 128'(0));
`endif
            bus.i_post_ready = 1'b1;
         end
      join
      wait_bundles(NBUN);
      check("acc_count_hold", 128'(acc_cnt), 128'(NPIX));

      // Frame 3: random input gaps and random downstream ready
      clear_mon();
      rnd_done = 1'b0;
      fork
         send_frame(NPIX, 50);
         begin
            while (!rnd_done) begin
               bus.i_post_ready = 1'($urandom_range(1));
               @(posedge clk); #1;
            end
         end
         begin
            wait_bundles(NBUN);
            rnd_done = 1'b1;
         end
      join
      bus.i_post_ready = 1'b1;
      check("acc_count_rnd", 128'(acc_cnt), 128'(NPIX));

      // Frame 4: reset while bundle 8 (after row 10) is held
      clear_mon();
      bus.i_post_ready = 1'b1;
      fork
         send_frame(11 * IMG_W, 0);
         hold_at_row(8, 3);
      join
      check("pre_rst_valid", 128'(bus.o_post_valid), 128'(1));
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", 128'(bus.o_post_valid), 128'(0));
      check("midrst_row", 128'(bus.o_row), 128'(0));
      check("midrst_ready", 128'(bus.o_pre_ready), 128'(1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_post_ready = 1'b1;
      clear_mon();
      @(posedge clk); #1;
      send_frame(NPIX, 0);
      wait_bundles(NBUN);
      check("acc_count_post_rst", 128'(acc_cnt), 128'(NPIX));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
